// File: rtl/occupancy_state_controller.sv
// ---------------------------------------------------------------------------
// occupancy_state_controller
//
// Produces the 2-bit lighting state for the automatic-lighting FSM. The raw
// motion sensor and manual pushbutton are each passed through a 2-flop
// synchroniser and a consecutive-sample debounce filter. The filtered values
// then drive the occupancy state machine, which includes a hold-off timer.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive differing synchronised samples needed
//                     before a filtered input flips (>= 1)
//   HOLD_CYCLES     - cycles the light stays in HOLD once motion ceases (>= 1)
//
// Ports:
//   Clock          in   system clock, rising edge
//   Reset_n        in   asynchronous active-low reset
//   Motion         in   raw occupancy sensor (asynchronous), 1 = motion
//   Manual_Btn     in   raw manual-override button (asynchronous), 1 = pressed
//   Present_State  out  00 OFF, 01 ON, 10 HOLD, 11 MANUAL (state register)
//   Expire_Pulse   out  one-cycle pulse after the HOLD->OFF timeout edge
// ---------------------------------------------------------------------------
module occupancy_state_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Motion,
  input  logic       Manual_Btn,
  output logic [1:0] Present_State,
  output logic       Expire_Pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // A single-cycle hold still needs a one-bit timer register.
  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_ON     = 2'b01,
    ST_HOLD   = 2'b10,
    ST_MANUAL = 2'b11
  } state_t;

  // Channel 0 is motion, channel 1 is the button.
  logic [1:0] raw_in;
  logic [1:0] filt;

  assign raw_in = {Manual_Btn, Motion};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_input
      logic             sync1_reg;
      logic             sync2_reg;
      logic             filt_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          filt_reg  <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
          // Any agreeing sample restarts the run; the filtered value only
          // flips after an unbroken run of DEBOUNCE_CYCLES differing samples.
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            filt_reg <= ~filt_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  logic mot;
  logic btn_evt;
  logic btn_prev_reg;

  assign mot     = filt[0];
  // Press event only; releasing the button is deliberately ignored.
  assign btn_evt = filt[1] & ~btn_prev_reg;

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             expire_reg, expire_next;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_OFF;
      timer_reg    <= '0;
      expire_reg   <= 1'b0;
      btn_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      expire_reg   <= expire_next;
      btn_prev_reg <= filt[1];
    end
  end

  // Button event takes priority in every state. The timer is only touched
  // in ON (load) and HOLD (decrement while non-zero), so it never wraps.
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    expire_next = 1'b0;
    case (state_reg)
      ST_OFF: begin
        if (btn_evt) begin
          state_next = ST_MANUAL;
        end else if (mot) begin
          state_next = ST_ON;
        end
      end
      ST_ON: begin
        if (btn_evt) begin
          state_next = ST_MANUAL;
        end else if (!mot) begin
          state_next = ST_HOLD;
          timer_next = TMR_LOAD;
        end
      end
      ST_HOLD: begin
        if (btn_evt) begin
          state_next = ST_MANUAL;
        end else if (mot) begin
          state_next = ST_ON;
        end else if (timer_reg == '0) begin
          state_next  = ST_OFF;
          expire_next = 1'b1;
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      ST_MANUAL: begin
        if (btn_evt) begin
          state_next = ST_OFF;
        end
      end
      default: begin
        state_next = ST_OFF;
      end
    endcase
  end

  assign Present_State = state_reg;
  assign Expire_Pulse  = expire_reg;

endmodule

// File: tb/tb_occupancy_state_controller.sv
// ---------------------------------------------------------------------------
// tb_occupancy_state_controller
//
// Directed scenarios followed by randomised motion/button/reset traffic.
// Outputs are compared every cycle against a reference model that works from
// the behavioural rules: a raw-sample history stands in for synchronisation,
// a "last N samples all disagree" window stands in for debouncing, and the
// hold timeout is measured as elapsed edges since HOLD was entered.
// ---------------------------------------------------------------------------
module tb_occupancy_state_controller;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int HOLD_CYCLES     = 16;

  localparam logic [1:0] S_OFF    = 2'b00;
  localparam logic [1:0] S_ON     = 2'b01;
  localparam logic [1:0] S_HOLD   = 2'b10;
  localparam logic [1:0] S_MANUAL = 2'b11;

  logic       Clock;
  logic       Reset_n;
  logic       Motion;
  logic       Manual_Btn;
  logic [1:0] Present_State;
  logic       Expire_Pulse;

  occupancy_state_controller #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Motion       (Motion),
    .Manual_Btn   (Manual_Btn),
    .Present_State(Present_State),
    .Expire_Pulse (Expire_Pulse)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int vectors;
  int miscompares;

  // ---------------- reference model ----------------
  logic [1:0]  m_state;
  logic        m_exp;
  bit          m_mot;
  bit          m_btn;
  bit          m_btn_prev;
  int unsigned n_edge;
  int unsigned hold_start;
  bit          raw_mot_q[$];
  bit          raw_btn_q[$];
  bit          smp_mot_q[$];
  bit          smp_btn_q[$];

  // True when the most recent DEBOUNCE_CYCLES samples all disagree with filt.
  function automatic bit window_flips(input bit q[$], input bit filt);
    if (q.size() < DEBOUNCE_CYCLES) return 1'b0;
    for (int i = q.size() - DEBOUNCE_CYCLES; i < q.size(); i++) begin
      if (q[i] == filt) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state    = S_OFF;
    m_exp      = 1'b0;
    m_mot      = 1'b0;
    m_btn      = 1'b0;
    m_btn_prev = 1'b0;
    n_edge     = 0;
    hold_start = 0;
    // Two cleared synchroniser stages: the next two samples seen are zero.
    raw_mot_q  = '{1'b0, 1'b0};
    raw_btn_q  = '{1'b0, 1'b0};
    smp_mot_q  = {};
    smp_btn_q  = {};
  endtask

  task automatic model_step(input bit raw_m, input bit raw_b);
    bit evt;
    bit s_m;
    bit s_b;
    n_edge++;
    evt   = m_btn && !m_btn_prev;
    m_exp = 1'b0;
    case (m_state)
      S_OFF:  if (evt) m_state = S_MANUAL; else if (m_mot) m_state = S_ON;
      S_ON: begin
        if (evt) m_state = S_MANUAL;
        else if (!m_mot) begin
          m_state    = S_HOLD;
          hold_start = n_edge;
        end
      end
      S_HOLD: begin
        if (evt) m_state = S_MANUAL;
        else if (m_mot) m_state = S_ON;
        else if (n_edge - hold_start == HOLD_CYCLES) begin
          m_state = S_OFF;
          m_exp   = 1'b1;
        end
      end
      default: if (evt) m_state = S_OFF;
    endcase
    // A raw value reaches the debounce filter two edges after it is sampled.
    raw_mot_q.push_back(raw_m);
    raw_btn_q.push_back(raw_b);
    s_m = raw_mot_q[raw_mot_q.size() - 3];
    s_b = raw_btn_q[raw_btn_q.size() - 3];
    smp_mot_q.push_back(s_m);
    smp_btn_q.push_back(s_b);
    while (raw_mot_q.size() > 16) raw_mot_q.delete(0);
    while (raw_btn_q.size() > 16) raw_btn_q.delete(0);
    while (smp_mot_q.size() > 16) smp_mot_q.delete(0);
    while (smp_btn_q.size() > 16) smp_btn_q.delete(0);
    m_btn_prev = m_btn;
    if (window_flips(smp_mot_q, m_mot)) m_mot = !m_mot;
    if (window_flips(smp_btn_q, m_btn)) m_btn = !m_btn;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive raw inputs, let the edge happen, check 1 time unit later.
  task automatic tick(input bit m, input bit b);
    Motion     = m;
    Manual_Btn = b;
    @(posedge Clock);
    if (Reset_n) model_step(m, b);
    else         model_reset();
    #1;
    check2("state", Present_State, m_state);
    check2("expire", {1'b0, Expire_Pulse}, {1'b0, m_exp});
  endtask

  task automatic ticks(input int n, input bit m, input bit b);
    for (int i = 0; i < n; i++) tick(m, b);
  endtask

  // Motion low until the model enters HOLD (bounded).
  task automatic wait_hold();
    for (int i = 0; i < 20; i++) begin
      if (m_state == S_HOLD) break;
      tick(1'b0, 1'b0);
    end
    check2("reach_hold", Present_State, S_HOLD);
  endtask

  // Motion low until the light goes off; counts HOLD cycles and pulses.
  task automatic measure_hold(output int hold_cnt, output int pulse_cnt);
    hold_cnt  = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b0);
      if (Present_State == S_HOLD) hold_cnt++;
      if (Expire_Pulse) pulse_cnt++;
      if (hold_cnt > 0 && Present_State == S_OFF) break;
    end
    tick(1'b0, 1'b0);
    if (Expire_Pulse) pulse_cnt++;
  endtask

  int hold_cnt;
  int pulse_cnt;
  int on_edge;
  int len;
  bit rm;
  bit rb;

  initial begin
    vectors     = 0;
    miscompares = 0;
    Motion      = 1'b0;
    Manual_Btn  = 1'b0;
    Reset_n     = 1'b1;
    model_reset();

    // Power-on reset, checked asynchronously before any clock edge.
    #2 Reset_n = 1'b0;
    #1;
    check2("reset_state", Present_State, S_OFF);
    check2("reset_expire", {1'b0, Expire_Pulse}, 2'b00);
    ticks(2, 1'b0, 1'b0);
    Reset_n = 1'b1;
    $display("step reset: state=%b expire=%b", Present_State, Expire_Pulse);

    // Glitch rejection: 3-cycle motion pulse must be ignored.
    ticks(3, 1'b1, 1'b0);
    ticks(12, 1'b0, 1'b0);
    check2("glitch_off", Present_State, S_OFF);
    $display("step glitch: state=%b", Present_State);

    // Normal cycle: OFF -> ON -> HOLD for HOLD_CYCLES -> OFF with one pulse.
    ticks(10, 1'b1, 1'b0);
    check2("normal_on", Present_State, S_ON);
    measure_hold(hold_cnt, pulse_cnt);
    check_int("normal_hold_len", hold_cnt, HOLD_CYCLES);
    check_int("normal_pulses", pulse_cnt, 1);
    check2("normal_off", Present_State, S_OFF);
    $display("step normal: hold=%0d pulses=%0d", hold_cnt, pulse_cnt);

    // Re-trigger: motion returns mid-HOLD, then a fresh full hold.
    ticks(10, 1'b1, 1'b0);
    wait_hold();
    ticks(4, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0);
    check2("retrig_on", Present_State, S_ON);
    measure_hold(hold_cnt, pulse_cnt);
    check_int("retrig_hold_len", hold_cnt, HOLD_CYCLES);
    check_int("retrig_pulses", pulse_cnt, 1);
    $display("step retrigger: hold=%0d pulses=%0d", hold_cnt, pulse_cnt);

    // Manual override from ON, sticky through motion changes.
    ticks(10, 1'b1, 1'b0);
    ticks(8, 1'b1, 1'b1);
    check2("manual_enter", Present_State, S_MANUAL);
    ticks(8, 1'b1, 1'b0);
    ticks(10, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0);
    check2("manual_sticky", Present_State, S_MANUAL);
    // Second press with motion high: MANUAL -> OFF -> ON on consecutive edges.
    for (int i = 0; i < 12; i++) begin
      if (Present_State != S_MANUAL) break;
      tick(1'b1, 1'b1);
    end
    check2("manual_exit_off", Present_State, S_OFF);
    tick(1'b1, 1'b1);
    check2("manual_then_on", Present_State, S_ON);
    ticks(8, 1'b1, 1'b0);
    $display("step manual: state=%b", Present_State);

    // Button event lands on the same edge as the HOLD timeout.
    // HOLD entered at edge t; press first sampled at edge t+10 resolves at t+16.
    wait_hold();
    ticks(9, 1'b0, 1'b0);
    ticks(7, 1'b0, 1'b1);
    check2("prio_manual", Present_State, S_MANUAL);
    check2("prio_no_pulse", {1'b0, Expire_Pulse}, 2'b00);
    ticks(8, 1'b0, 1'b0);
    $display("step priority: state=%b expire=%b", Present_State, Expire_Pulse);

    // Leave MANUAL, return to HOLD, then reset asynchronously mid-HOLD.
    ticks(8, 1'b0, 1'b1);
    ticks(8, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0);
    wait_hold();
    ticks(3, 1'b0, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check2("async_reset_state", Present_State, S_OFF);
    check2("async_reset_expire", {1'b0, Expire_Pulse}, 2'b00);
    ticks(2, 1'b1, 1'b0);
    Reset_n = 1'b1;
    // First edge after release samples Motion (k=1); ON appears at k+2+DEBOUNCE_CYCLES.
    on_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(1'b1, 1'b0);
      if (on_edge == 0 && Present_State == S_ON) on_edge = e;
    end
    check_int("reset_to_on_edges", on_edge, DEBOUNCE_CYCLES + 3);
    $display("step reset_latency: on_edge=%0d", on_edge);

    // Randomised traffic with occasional asynchronous resets.
    for (int burst = 0; burst < 220; burst++) begin
      len = $urandom_range(1, 8);
      rm  = 1'($urandom_range(0, 1));
      rb  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        check2("rand_async_reset", Present_State, S_OFF);
        tick(rm, rb);
        Reset_n = 1'b1;
      end
      ticks(len, rm, rb);
    end
    $display("step random: state=%b", Present_State);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
